// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: definitions shared by the LED matrix scanner and its sub-modules.
//   MATRIX_DIM    - rows and columns of the matrix
//   ROW_W         - width of the row counter
//   scan_state_e  - scanner FSM states (IDLE, BLANK, DRIVE)
//   row_onehot()  - one-hot row select decode
package led_matrix_pkg;

    localparam int unsigned MATRIX_DIM = 16;
    localparam int unsigned ROW_W      = $clog2(MATRIX_DIM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    function automatic logic [MATRIX_DIM-1:0] row_onehot(input logic [ROW_W-1:0] row);
        logic [MATRIX_DIM-1:0] one;
        one = {{(MATRIX_DIM-1){1'b0}}, 1'b1};
        return one << row;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_scan_timer.sv
// scan_timer: loadable down-counter that times the BLANK and DRIVE phases.
//   clk_i      - clock, rising edge
//   reset_i    - synchronous active-high reset, clears the count
//   load_i     - load load_val_i into the counter on this edge
//   load_val_i - value to load (duration minus one)
//   done_o     - high while the count is zero (last cycle of the phase)
module scan_timer #(
    parameter int unsigned TIMER_W = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: scans a 16x16 red/green LED matrix one row at a time.
// Each row is preceded by BLANK_CYCLES all-off clocks and then driven for DWELL_CYCLES
// clocks. The pixel images are captured into shadow registers at each frame start so a
// frame never tears.
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   EN         - scan enable; dropping it returns to IDLE with all outputs off
//   RedPixels  - requested red image, [row][col]
//   GrnPixels  - requested green image, [row][col]
//   RowSel     - one-hot active row (zero while blanking or idle)
//   RedCol     - red column drive for the active row
//   GrnCol     - green column drive for the active row
//   FrameStart - one-cycle pulse on the first clock of row 0
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   EN,
    input  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0]  RedPixels,
    input  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0]  GrnPixels,
    output logic [MATRIX_DIM-1:0]                  RowSel,
    output logic [MATRIX_DIM-1:0]                  RedCol,
    output logic [MATRIX_DIM-1:0]                  GrnCol,
    output logic                                   FrameStart
);

    localparam int unsigned TIMER_W        = 16;
    localparam int unsigned BLANK_LOAD_INT = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
    localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(BLANK_LOAD_INT);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(MATRIX_DIM - 1);

    scan_state_e                          state_q, state_d;
    logic [ROW_W-1:0]                     row_q, row_d;
    logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] shadow_red_q, shadow_red_d;
    logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] shadow_grn_q, shadow_grn_d;
    logic [MATRIX_DIM-1:0]                rowsel_q, rowsel_d;
    logic [MATRIX_DIM-1:0]                red_col_q, red_col_d;
    logic [MATRIX_DIM-1:0]                grn_col_q, grn_col_d;
    logic                                 frame_start_q, frame_start_d;

    logic                                 timer_load;
    logic [TIMER_W-1:0]                   timer_load_val;
    logic                                 timer_done;
    logic                                 capture;

    scan_timer #(
        .TIMER_W (TIMER_W)
    ) u_scan_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .done_o     (timer_done)
    );

    // Next state, row and timer control. EN=0 overrides any expiry on the same edge.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        timer_load     = 1'b0;
        timer_load_val = '0;
        capture        = 1'b0;
        frame_start_d  = 1'b0;

        if (!EN) begin
            state_d    = IDLE;
            row_d      = '0;
            timer_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    row_d         = '0;
                    capture       = 1'b1;
                    frame_start_d = 1'b1;
                    timer_load    = 1'b1;
                    if (BLANK_CYCLES == 0) begin
                        state_d        = DRIVE;
                        timer_load_val = DWELL_LOAD;
                    end else begin
                        state_d        = BLANK;
                        timer_load_val = BLANK_LOAD;
                    end
                end
                BLANK: begin
                    if (timer_done) begin
                        state_d        = DRIVE;
                        timer_load     = 1'b1;
                        timer_load_val = DWELL_LOAD;
                    end
                end
                DRIVE: begin
                    if (timer_done) begin
                        row_d      = row_q + 1'b1;
                        timer_load = 1'b1;
                        // Wrapping past the last row begins a new frame.
                        if (row_q == LAST_ROW) begin
                            capture       = 1'b1;
                            frame_start_d = 1'b1;
                        end
                        if (BLANK_CYCLES == 0) begin
                            state_d        = DRIVE;
                            timer_load_val = DWELL_LOAD;
                        end else begin
                            state_d        = BLANK;
                            timer_load_val = BLANK_LOAD;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = '0;
                end
            endcase
        end
    end

    // Shadow capture and output decode. Outputs are registered from the next state so
    // they line up with the state they describe and have no combinational input path.
    always_comb begin
        shadow_red_d = capture ? RedPixels : shadow_red_q;
        shadow_grn_d = capture ? GrnPixels : shadow_grn_q;
        rowsel_d     = '0;
        red_col_d    = '0;
        grn_col_d    = '0;
        if (state_d == DRIVE) begin
            rowsel_d  = row_onehot(row_d);
            red_col_d = shadow_red_d[row_d];
            grn_col_d = shadow_grn_d[row_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            shadow_red_q  <= '0;
            shadow_grn_q  <= '0;
            rowsel_q      <= '0;
            red_col_q     <= '0;
            grn_col_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            shadow_red_q  <= shadow_red_d;
            shadow_grn_q  <= shadow_grn_d;
            rowsel_q      <= rowsel_d;
            red_col_q     <= red_col_d;
            grn_col_q     <= grn_col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign RowSel     = rowsel_q;
    assign RedCol     = red_col_q;
    assign GrnCol     = grn_col_q;
    assign FrameStart = frame_start_q;

endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000, meaning clocks each row is driven; legal range 1..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 4, meaning all-off clocks before each row (anti-ghosting); legal range 0..255.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port EN, input, 1 bit, meaning scan enable.
REQ-006 SHALL have port RedPixels, input, [15:0][15:0], meaning the requested red image; [row][col].
REQ-007 SHALL have port GrnPixels, input, [15:0][15:0], meaning the requested green image; [row][col].
REQ-008 SHALL have port RowSel, output, 16 bits, meaning the one-hot active row; bit r drives row r.
REQ-009 SHALL have port RedCol, output, 16 bits, meaning the red column drive for the active row; bit c drives column c.
REQ-010 SHALL have port GrnCol, output, 16 bits, meaning the green column drive for the active row.
REQ-011 SHALL have port FrameStart, output, 1 bit, meaning a one-cycle pulse on the cycle a new frame is captured.

Function
REQ-012 SHALL implement the states IDLE, BLANK and DRIVE, plus a 4-bit row counter and a 16-bit phase counter.
REQ-013 SHALL transition IDLE -> BLANK(row 0) on an edge where EN=1, or IDLE -> DRIVE(row 0) if BLANK_CYCLES=0.
REQ-014 SHALL hold BLANK for exactly BLANK_CYCLES clocks and then go to DRIVE with the same row.
REQ-015 SHALL hold DRIVE for exactly DWELL_CYCLES clocks and then go to BLANK (or DRIVE if BLANK_CYCLES=0) with row+1.
REQ-016 SHALL wrap the row from 15 to 0, and that wrap SHALL begin a new frame.
REQ-017 SHALL, at frame begin, copy RedPixels and GrnPixels into shadow registers on the same edge that enters row 0; shadow contents SHALL be constant for the whole frame (no tearing).
REQ-018 SHALL assert FrameStart for exactly the first clock of row 0 (first BLANK cycle, or first DRIVE cycle if BLANK_CYCLES=0).
REQ-019 SHALL, in DRIVE, set RowSel = 1<<row, RedCol = shadowRed[row] and GrnCol = shadowGrn[row].
REQ-020 SHALL, in IDLE and BLANK, drive RowSel, RedCol and GrnCol all to 0.
REQ-021 SHALL never drive more than one RowSel bit high in any cycle.
REQ-022 SHALL drive outputs directly from flops or from a decode of registered state only, with no combinational path from EN or the pixel inputs.
REQ-023 SHALL make the frame period exactly 16*(BLANK_CYCLES+DWELL_CYCLES) clocks.
REQ-024 SHALL, on EN=0 in any state, go to IDLE on the next edge; all outputs SHALL be 0 from that cycle; the row SHALL be cleared to 0.
REQ-025 SHALL, on EN reasserted, restart at row 0 with a fresh capture; a partial frame is never resumed.
REQ-026 SHALL give EN=0 priority over every counter expiry occurring on the same edge.
REQ-027 SHALL make pixel input changes mid-frame visible only from the next frame start.

Reset
REQ-028 SHALL, when reset=1 is sampled on an edge, set state IDLE, row 0, phase 0, shadows 0, and RowSel, RedCol, GrnCol and FrameStart all 0.
REQ-029 SHALL give reset priority over EN and all counters, including mid-DRIVE.
REQ-030 SHALL, after reset deasserts with EN=1, enter row 0 on the first edge with reset=0.

Structure
REQ-031 SHALL place the state enum (IDLE, BLANK, DRIVE) and the constant MATRIX_DIM=16 in shared package led_matrix_pkg.
REQ-032 SHALL use one sub-module, scan_timer, a loadable down-counter with a done flag that provides the BLANK and DRIVE durations.

Verification
REQ-033 SHALL cover this scenario: DWELL=4, BLANK=2, EN=1, RedPixels[r]=16'h0001<<r, GrnPixels=0 -> each row gives 2 cycles of all-zero, then 4 cycles with RowSel=RedCol=1<<r; FrameStart pulses every 96 cycles.
REQ-034 SHALL cover this scenario: GrnPixels changed from all-0 to all-FFFF during row 7 -> GrnCol stays 0 through row 15; GrnCol=16'hFFFF from row 0 of the next frame.
REQ-035 SHALL cover this scenario: EN dropped during row 9 DRIVE -> all outputs 0 on the next cycle; EN raised 10 cycles later -> FrameStart=1 and row 0 within 1 cycle.
REQ-036 SHALL cover this scenario: reset pulsed for 1 cycle during row 3 DRIVE -> all outputs 0 on the next cycle; with EN=1, the scan restarts at row 0 with FrameStart=1.
REQ-037 SHALL cover this scenario: BLANK=0, DWELL=1 -> RowSel walks 0001, 0002, ... 8000, 0001 on consecutive cycles, never 0 between rows, and FrameStart=1 every 16 cycles.
REQ-038 SHALL check these invariants throughout every scenario: $countones(RowSel)<=1, and RedCol=GrnCol=0 whenever RowSel=0.
